// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic light controller and its phase timer,
// plus helpers that decode the controller's one-hot light outputs.
package traffic_pkg;

    // Matches the controller's s0/s1/s2 state encoding.
    typedef enum logic [1:0] {
        PH_RED    = 2'b00,
        PH_GREEN  = 2'b01,
        PH_YELLOW = 2'b10
    } phase_e;

    typedef enum logic [1:0] {
        S_LOAD  = 2'b00,
        S_COUNT = 2'b01,
        S_FIRE  = 2'b10,
        S_WAIT  = 2'b11
    } tstate_e;

    function automatic logic lights_onehot(input logic r, input logic g, input logic y);
        return (r ^ g ^ y) & ~(r & g & y);
    endfunction

    // Only meaningful when lights_onehot() is true.
    function automatic phase_e lights_to_phase(input logic r, input logic g, input logic y);
        phase_e ph;
        ph = PH_RED;
        if (r)      ph = PH_RED;
        else if (g) ph = PH_GREEN;
        else if (y) ph = PH_YELLOW;
        return ph;
    endfunction

endpackage

// File: rtl/traffic_phase_timer_if.sv
// Signal bundle between the light controller (master) and the phase timer (slave).
interface traffic_phase_timer_if #(
    parameter int CNT_W = 8
);
    logic             Red;
    logic             Green;
    logic             Yellow;
    logic             ped_req;
    logic             advance;
    logic [CNT_W-1:0] remaining;
    logic             ped_ack;
    logic             fault;

    modport master (
        output Red, Green, Yellow, ped_req,
        input  advance, remaining, ped_ack, fault
    );

    modport slave (
        input  Red, Green, Yellow, ped_req,
        output advance, remaining, ped_ack, fault
    );
endinterface

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled clocks.
module tick_prescaler #(
    parameter int TICK_DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == CW'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear)   cnt_d = '0;
        else if (en) cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/traffic_phase_timer.sv
// Times each controller light phase in prescaled ticks and strobes advance
// when the dwell expires; pedestrian requests may shorten Green.
module traffic_phase_timer
    import traffic_pkg::*;
#(
    parameter int TICK_DIV    = 10,
    parameter int RED_TIME    = 8,
    parameter int GREEN_TIME  = 6,
    parameter int YELLOW_TIME = 2,
    parameter int MIN_GREEN   = 2,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    traffic_phase_timer_if.slave bus
);
    tstate_e          state_q, state_d;
    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             pend_q, pend_d;
    logic             fault_q, fault_d;

    logic             lights_ok;
    phase_e           phase_in;
    logic [CNT_W-1:0] phase_dur;
    logic [CNT_W-1:0] rem_new;
    logic [CNT_W-1:0] green_elapsed;
    logic             tick;
    logic             ped_ack_c;

    assign lights_ok = lights_onehot(bus.Red, bus.Green, bus.Yellow);
    assign phase_in  = lights_to_phase(bus.Red, bus.Green, bus.Yellow);

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (state_q == S_LOAD),
        .en    (state_q == S_COUNT),
        .tick  (tick)
    );

    always_comb begin
        case (phase_in)
            PH_GREEN:  phase_dur = CNT_W'(GREEN_TIME);
            PH_YELLOW: phase_dur = CNT_W'(YELLOW_TIME);
            default:   phase_dur = CNT_W'(RED_TIME);
        endcase
    end

    // Saturating decrement; remaining never wraps below zero.
    always_comb begin
        rem_new = remaining_q;
        if (tick && (remaining_q != '0)) rem_new = remaining_q - CNT_W'(1);
    end

    assign green_elapsed = CNT_W'(GREEN_TIME) - rem_new;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        remaining_d = remaining_q;
        pend_d      = pend_q | bus.ped_req;
        fault_d     = ~lights_ok;
        ped_ack_c   = 1'b0;

        if (!lights_ok) begin
            state_d = S_LOAD;
        end else begin
            case (state_q)
                S_LOAD: begin
                    remaining_d = phase_dur;
                    phase_d     = phase_in;
                    state_d     = S_COUNT;
                    // Serving the request wins over a same-cycle new request.
                    if ((phase_in == PH_RED) && pend_q) begin
                        pend_d    = 1'b0;
                        ped_ack_c = 1'b1;
                    end
                end
                S_COUNT: begin
                    if (phase_in != phase_q) begin
                        state_d = S_LOAD;
                    end else begin
                        remaining_d = rem_new;
                        if (rem_new == '0)
                            state_d = S_FIRE;
                        else if ((phase_q == PH_GREEN) && pend_q &&
                                 (green_elapsed >= CNT_W'(MIN_GREEN)))
                            state_d = S_FIRE;
                    end
                end
                S_FIRE: state_d = S_WAIT;
                S_WAIT: if (phase_in != phase_q) state_d = S_LOAD;
                default: state_d = S_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_LOAD;
            phase_q     <= PH_RED;
            remaining_q <= '0;
            pend_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            remaining_q <= remaining_d;
            pend_q      <= pend_d;
            fault_q     <= fault_d;
        end
    end

    assign bus.advance   = (state_q == S_FIRE);
    assign bus.remaining = remaining_q;
    assign bus.ped_ack   = ped_ack_c;
    assign bus.fault     = fault_q;
endmodule

// File: tb/tb_traffic_phase_timer.sv
// Closed-loop bench: a controller model feeds the timer, and a timestamp-based
// reference model predicts every output cycle by cycle.
module tb_traffic_phase_timer;
    localparam int TD = 10;
    localparam int RT = 8;
    localparam int GT = 6;
    localparam int YT = 2;
    localparam int MG = 2;
    localparam int CW = 8;
    localparam int FAR = 1 << 30;

    logic clk;
    logic reset;

    traffic_phase_timer_if #(.CNT_W(CW)) bus ();

    traffic_phase_timer #(
        .TICK_DIV(TD), .RED_TIME(RT), .GREEN_TIME(GT),
        .YELLOW_TIME(YT), .MIN_GREEN(MG), .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Controller / stimulus knobs (phase 0=Red, 1=Green, 2=Yellow).
    int       ctrl_ph = 0;
    int       bad_cnt = 0;
    logic [2:0] bad_pat = 3'b000;
    logic     req_drv = 1'b0;
    logic     rst_drv = 1'b0;
    int       acks    = 0;
    int       adv_t[$];
    int       adv_ph[$];

    // Reference model: cycle of the latest LOAD, cycle of the expected advance,
    // latched phase and its dwell, and the remaining value frozen across a LOAD.
    int m_load_t   = 0;
    int m_fire_t   = FAR;
    int m_lph      = 0;
    int m_ldur     = 0;
    int m_rem_prev = 0;
    bit m_pend     = 1'b0;
    bit m_fault    = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s cyc=%0d got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int dur_of(input int ph);
        case (ph)
            0:       return RT;
            1:       return GT;
            default: return YT;
        endcase
    endfunction

    function automatic int model_rem(input int t);
        int e, r;
        if (t <= m_load_t) return m_rem_prev;
        e = ((t < m_fire_t) ? t : m_fire_t) - m_load_t;
        r = m_ldur - (e - 1) / TD;
        return (r < 0) ? 0 : r;
    endfunction

    function automatic void model_reset(input int t);
        m_load_t   = t + 1;
        m_fire_t   = FAR;
        m_rem_prev = 0;
        m_pend     = 1'b0;
        m_fault    = 1'b0;
    endfunction

    // One clock: drive at posedge+1, check at negedge, advance model and controller.
    task automatic step();
        logic [2:0] lt;
        bit   valid;
        int   ph, stage, exp_rem;
        bit   exp_adv, exp_ack, new_pend;
        if (bad_cnt > 0) lt = bad_pat;
        else begin
            case (ctrl_ph)
                0:       lt = 3'b100;
                1:       lt = 3'b010;
                default: lt = 3'b001;
            endcase
        end
        bus.Red     = lt[2];
        bus.Green   = lt[1];
        bus.Yellow  = lt[0];
        bus.ped_req = req_drv;
        reset       = rst_drv;
        @(negedge clk);
        if (!rst_drv) begin
            check_eq("rst_advance",   bus.advance,   0);
            check_eq("rst_remaining", bus.remaining, 0);
            check_eq("rst_ped_ack",   bus.ped_ack,   0);
            check_eq("rst_fault",     bus.fault,     0);
            model_reset(cyc);
        end else begin
            valid = (lt == 3'b100) || (lt == 3'b010) || (lt == 3'b001);
            ph    = lt[2] ? 0 : (lt[1] ? 1 : 2);
            if (cyc == m_load_t)      stage = 0;
            else if (cyc < m_fire_t)  stage = 1;
            else if (cyc == m_fire_t) stage = 2;
            else                      stage = 3;
            exp_adv = (stage == 2);
            exp_rem = model_rem(cyc);
            exp_ack = (stage == 0) && valid && (ph == 0) && m_pend;
            check_eq("advance",   bus.advance,   exp_adv);
            check_eq("remaining", bus.remaining, exp_rem);
            check_eq("ped_ack",   bus.ped_ack,   exp_ack);
            check_eq("fault",     bus.fault,     m_fault);

            new_pend = exp_ack ? 1'b0 : (m_pend | req_drv);
            if (!valid) begin
                m_rem_prev = exp_rem;
                m_load_t   = cyc + 1;
            end else if (stage == 0) begin
                m_lph    = ph;
                m_ldur   = dur_of(ph);
                m_fire_t = cyc + 1 + m_ldur * TD;
            end else if ((stage == 1 || stage == 3) && ph != m_lph) begin
                m_rem_prev = exp_rem;
                m_load_t   = cyc + 1;
            end else if (stage == 1 && m_lph == 1 && m_pend &&
                         (cyc - m_load_t) >= MG * TD && cyc + 1 < m_fire_t) begin
                m_fire_t = cyc + 1;
            end
            m_pend  = new_pend;
            m_fault = !valid;
        end
        if (bus.advance === 1'b1) begin
            $display("[TB] cyc=%0d advance phase=%0d remaining=%0d", cyc, ctrl_ph, bus.remaining);
            adv_t.push_back(cyc);
            adv_ph.push_back(ctrl_ph);
            ctrl_ph = (ctrl_ph + 1) % 3;
        end
        if (bus.ped_ack === 1'b1) acks++;
        if (bad_cnt > 0) bad_cnt--;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic async_reset();
        reset   = 1'b0;
        rst_drv = 1'b0;
        #1;
        check_eq("async_advance",   bus.advance,   0);
        check_eq("async_remaining", bus.remaining, 0);
        check_eq("async_ped_ack",   bus.ped_ack,   0);
        check_eq("async_fault",     bus.fault,     0);
    endtask

    // Step until the controller enters a fresh Red phase, then extra cycles.
    task automatic wait_red(input int extra);
        int k;
        k = 0;
        while (ctrl_ph == 0 && k < 600) begin step(); k++; end
        while (ctrl_ph != 0 && k < 600) begin step(); k++; end
        check_eq("wait_red", ctrl_ph, 0);
        repeat (extra) step();
    endtask

    initial begin
        int rel, k, hold_left;
        reset = 1'b1;
        bus.Red = 1'b1; bus.Green = 1'b0; bus.Yellow = 1'b0; bus.ped_req = 1'b0;
        #1;
        reset   = 1'b0;
        rst_drv = 1'b0;
        repeat (3) step();

        // Free-running cycle: dwell lengths and full period.
        rst_drv = 1'b1;
        rel = cyc;
        k = 0;
        while (adv_t.size() < 4 && k < 700) begin step(); k++; end
        check_eq("adv_count", adv_t.size() >= 4, 1);
        if (adv_t.size() >= 4) begin
            check_eq("first_red_adv", adv_t[0] - rel, RT * TD + 1);
            for (int i = 0; i < 3; i++)
                check_eq("dwell", adv_t[i+1] - adv_t[i], dur_of((adv_ph[i] + 1) % 3) * TD + 3);
            check_eq("period", adv_t[3] - adv_t[0], (RT + GT + YT) * TD + 9);
        end

        // Single pedestrian pulse during Red.
        wait_red(10);
        req_drv = 1'b1; step(); req_drv = 1'b0;
        adv_t.delete(); adv_ph.delete(); acks = 0;
        k = 0;
        while (adv_t.size() < 2 && k < 400) begin step(); k++; end
        check_eq("ped_ack_early", acks, 0);
        if (adv_t.size() >= 2) check_eq("green_cut", adv_t[1] - adv_t[0], MG * TD + 3);
        while (adv_t.size() < 3 && k < 800) begin step(); k++; end
        repeat (3) step();
        check_eq("ped_ack_once", acks, 1);

        // Request held high across Red LOAD.
        acks = 0;
        req_drv = 1'b1;
        repeat (250) step();
        req_drv = 1'b0;
        check_eq("held_ack", acks >= 1, 1);

        // Malformed lights mid-COUNT.
        wait_red(15);
        bad_pat = 3'b110; bad_cnt = 3;
        step();
        check_eq("fault_set", bus.fault, 1);
        step(); step(); step();
        check_eq("fault_clear", bus.fault, 0);
        step();

        // Unrequested Red -> Yellow during COUNT.
        wait_red(15);
        ctrl_ph = 2;
        step(); step();
        check_eq("force_reload", bus.remaining, YT);
        repeat (5) step();

        // Asynchronous reset mid-COUNT.
        wait_red(20);
        async_reset();
        step();
        rst_drv = 1'b1;
        step();
        check_eq("rst_reload", bus.remaining, RT);

        // Randomized closed-loop run.
        hold_left = 0;
        for (int i = 0; i < 5000; i++) begin
            if (hold_left > 0) hold_left--;
            else if ($urandom_range(0, 299) == 0) hold_left = $urandom_range(20, 200);
            req_drv = (hold_left > 0) || ($urandom_range(0, 99) < 3);
            if (bad_cnt == 0 && $urandom_range(0, 399) == 0) begin
                bad_cnt = $urandom_range(1, 3);
                case ($urandom_range(0, 4))
                    0:       bad_pat = 3'b000;
                    1:       bad_pat = 3'b110;
                    2:       bad_pat = 3'b011;
                    3:       bad_pat = 3'b101;
                    default: bad_pat = 3'b111;
                endcase
            end
            if ($urandom_range(0, 699) == 0) ctrl_ph = (ctrl_ph + 1 + int'($urandom_range(0, 1))) % 3;
            if ($urandom_range(0, 1999) == 0) begin
                async_reset();
                step();
                rst_drv = 1'b1;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got timeout expected finish", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
